// File: rtl/axi_master_seq.sv
// Single-outstanding command sequencer: every command runs AR/R first, writes then add AW/W.
// Optional channel timeout with ERR state when AXI_MASTER_TIMEOUT_EN is defined.
`timescale 1ns/1ps
module axi_master_seq #(
  parameter int unsigned TIMEOUT_CYCLES = 15
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic       cmd_write,
  input  logic [3:0] cmd_addr,
  input  logic [3:0] cmd_data,
  output logic       ms_arvalid,
  output logic [3:0] SWM_arADDR,
  input  logic       sm_arready,
  output logic       ms_rready,
  input  logic       sm_rvalid,
  output logic       ms_awvalid,
  input  logic       sm_awready,
  output logic       ms_wvalid,
  output logic [3:0] SWM_wdata,
  input  logic       sm_wready,
  output logic       busy,
  output logic       done,
  output logic       err
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_AR   = 3'd1;
  localparam logic [2:0] S_R    = 3'd2;
  localparam logic [2:0] S_AW   = 3'd3;
  localparam logic [2:0] S_W    = 3'd4;
  localparam logic [2:0] S_DONE = 3'd5;

  // Out-of-range TIMEOUT_CYCLES leaves a marker scope in the elaborated hierarchy.
  if (TIMEOUT_CYCLES == 0 || TIMEOUT_CYCLES > 255) begin : g_timeout_cycles_out_of_range
  end

  logic [2:0] state;
  logic [2:0] state_n;
  logic       wr_q;
  logic       accept;

  assign accept = (state == S_IDLE) && start;

`ifdef AXI_MASTER_TIMEOUT_EN
  localparam logic [2:0] S_ERR        = 3'd6;
  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

  logic [7:0] cnt;
  logic       waiting;

  assign waiting = (state == S_AR) || (state == S_R) || (state == S_AW) || (state == S_W);
`endif

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE: if (start)      state_n = S_AR;
      S_AR:   if (sm_arready) state_n = S_R;
      S_R:    if (sm_rvalid)  state_n = wr_q ? S_AW : S_DONE;
      S_AW:   if (sm_awready) state_n = S_W;
      S_W:    if (sm_wready)  state_n = S_DONE;
      S_DONE:                 state_n = S_IDLE;
`ifdef AXI_MASTER_TIMEOUT_EN
      S_ERR:                  state_n = S_IDLE;
`endif
      default:                state_n = S_IDLE;
    endcase
`ifdef AXI_MASTER_TIMEOUT_EN
    // A handshake on the expiring cycle wins over the timeout.
    if (waiting && (state_n == state) && (cnt == TIMEOUT_LAST)) state_n = S_ERR;
`endif
  end

  // Outputs are registered copies of the decode of the next state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      wr_q       <= 1'b0;
      SWM_arADDR <= '0;
      SWM_wdata  <= '0;
      ms_arvalid <= 1'b0;
      ms_rready  <= 1'b0;
      ms_awvalid <= 1'b0;
      ms_wvalid  <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state <= state_n;
      if (accept) begin
        wr_q       <= cmd_write;
        SWM_arADDR <= cmd_addr;
        SWM_wdata  <= cmd_data;
      end
      ms_arvalid <= (state_n == S_AR);
      ms_rready  <= (state_n == S_R);
      ms_awvalid <= (state_n == S_AW) || (state_n == S_W);
      ms_wvalid  <= (state_n == S_W);
      busy       <= (state_n != S_IDLE);
      done       <= (state_n == S_DONE);
    end
  end

`ifdef AXI_MASTER_TIMEOUT_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
      err <= 1'b0;
    end else begin
      cnt <= (state_n != state || !waiting) ? '0 : cnt + 8'd1;
      if (accept)                err <= 1'b0;
      else if (state_n == S_ERR) err <= 1'b1;
    end
  end
`else
  assign err = 1'b0;
`endif

endmodule

// File: doc/axi_master_seq.md
AXI_MASTER_SEQ -- requirements
Module: axi_master_seq

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 15, SHALL be the number of cycles a channel state waits before aborting (range 1-255).
REQ-002 clk  input  1  sole clock; all state SHALL change on the rising edge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  command request, sampled only in IDLE.
REQ-005 cmd_write  input  1  0 = read command, 1 = write command; latched with start.
REQ-006 cmd_addr  input  4  target address; latched with start.
REQ-007 cmd_data  input  4  write data; latched with start.
REQ-008 ms_arvalid  output  1  read-address valid.
REQ-009 SWM_arADDR  output  4  read address; equals latched cmd_addr.
REQ-010 sm_arready  input  1  read-address ready from the downstream slave.
REQ-011 ms_rready  output  1  read-data ready.
REQ-012 sm_rvalid  input  1  read-data valid.
REQ-013 ms_awvalid  output  1  write-address valid.
REQ-014 sm_awready  input  1  write-address ready.
REQ-015 ms_wvalid  output  1  write-data valid.
REQ-016 SWM_wdata  output  4  write data; equals latched cmd_data.
REQ-017 sm_wready  input  1  write-data ready.
REQ-018 busy  output  1  high in every state except IDLE.
REQ-019 done  output  1  one-cycle pulse on successful completion.
REQ-020 err  output  1  sticky timeout flag.

Function
REQ-021 The block SHALL be an FSM with states IDLE, AR, R, AW, W, DONE, ERR; all outputs registered.
REQ-022 IDLE: start=1 at an edge -> latch cmd_write/cmd_addr/cmd_data, clear err, go AR, ms_arvalid=1.
REQ-023 start SHALL be ignored in every state other than IDLE; no queuing.
REQ-024 AR: hold ms_arvalid=1; on an edge with sm_arready=1 -> R, ms_arvalid=0, ms_rready=1.
REQ-025 R: hold ms_rready=1; on an edge with sm_rvalid=1 -> ms_rready=0, then AW (ms_awvalid=1) if latched cmd_write=1, else DONE.
REQ-026 Every command, read or write, SHALL perform the AR/R phase first, because the slave uses the read address as the write destination.
REQ-027 AW: hold ms_awvalid=1; on an edge with sm_awready=1 -> W, ms_wvalid=1, ms_awvalid kept at 1.
REQ-028 W: hold ms_awvalid=1 and ms_wvalid=1; on an edge with sm_wready=1 -> DONE, both deasserted.
REQ-029 DONE: done=1 for exactly one cycle, then IDLE.
REQ-030 SWM_arADDR and SWM_wdata SHALL be stable from AR entry until IDLE return.
REQ-031 A ready or valid input that is high in a state not waiting for it SHALL be ignored.
REQ-032 At most one of ms_arvalid/ms_rready SHALL be high in any cycle; ms_wvalid=1 implies ms_awvalid=1.

Reset
REQ-033 reset_n=0 SHALL immediately force IDLE, all outputs 0, latched command 0, and timeout counter 0, including mid-transaction.
REQ-034 After release, the first start SHALL be accepted at the first rising edge where reset_n=1.

Configuration
REQ-035 Macro AXI_MASTER_TIMEOUT_EN defined: an 8-bit counter clears on every state entry and increments each cycle in AR/R/AW/W.
REQ-036 With the macro defined, when the count reaches TIMEOUT_CYCLES the FSM SHALL go to ERR, all valid/ready outputs SHALL be 0, and err SHALL be 1; the following cycle returns to IDLE with err held until the next accepted start.
REQ-037 Macro undefined: no counter or ERR logic SHALL exist, err SHALL be tied to 0, and waits are unbounded.

Verification
REQ-038 Read with a slave that asserts ready one cycle after valid: start at edge 0, cmd_addr=5 -> arvalid high in cycles 1-2, rready high in cycle 3, done pulse in cycle 4, busy high in cycles 1-4.
REQ-039 Write, cmd_addr=3, cmd_data=9, same slave -> AR/R as above, awvalid high in cycles 4-7, wvalid high in cycles 6-7, SWM_wdata=9 throughout, done in cycle 8.
REQ-040 start pulsed again in cycle 2 of a read with cmd_addr=7 -> ignored; SWM_arADDR stays 5; exactly one done pulse.
REQ-041 With the macro defined and TIMEOUT_CYCLES=4, sm_arready held 0 -> ERR after 4 AR cycles, err=1 and held; the next start clears err.
REQ-042 reset_n driven low during state W -> all outputs 0 asynchronously; after release, a new read completes normally.
